// File: rtl/mdu_iterative_pkg.sv
// Shared types for the EXE-stage multiply/divide unit: opcode encoding, MDU state
// and an opcode classifier used by the unit's start logic.
package mdu_iterative_pkg;

    typedef enum logic [6:0] {
        OP_NOP   = 7'd0,
        OP_ADD   = 7'd1,
        OP_SUB   = 7'd2,
        OP_AND   = 7'd3,
        OP_OR    = 7'd4,
        OP_MULT  = 7'd16,
        OP_MULTU = 7'd17,
        OP_DIV   = 7'd18,
        OP_DIVU  = 7'd19,
        OP_MADD  = 7'd20,
        OP_MADDU = 7'd21,
        OP_MSUB  = 7'd22,
        OP_MSUBU = 7'd23,
        OP_MUL   = 7'd24
    } InstrType;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    typedef struct packed {
        logic is_mul;
        logic is_div;
        logic is_sgn;
        logic is_acc;
        logic is_sub;
    } mdu_class_t;

    function automatic mdu_class_t mdu_classify(input logic [6:0] op);
        mdu_class_t c;
        c = '0;
        case (op)
            OP_MULT, OP_MUL: begin c.is_mul = 1'b1; c.is_sgn = 1'b1; end
            OP_MULTU:        c.is_mul = 1'b1;
            OP_MADD:  begin c.is_mul = 1'b1; c.is_sgn = 1'b1; c.is_acc = 1'b1; end
            OP_MADDU: begin c.is_mul = 1'b1; c.is_acc = 1'b1; end
            OP_MSUB:  begin c.is_mul = 1'b1; c.is_sgn = 1'b1; c.is_acc = 1'b1; c.is_sub = 1'b1; end
            OP_MSUBU: begin c.is_mul = 1'b1; c.is_acc = 1'b1; c.is_sub = 1'b1; end
            OP_DIV:   begin c.is_div = 1'b1; c.is_sgn = 1'b1; end
            OP_DIVU:        c.is_div = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/div_radix2_iter.sv
// 32-bit restoring radix-2 unsigned divider, one quotient bit per clock.
// done_o marks the cycle whose edge retires the last bit; results are the next-state values.
module div_radix2_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);
    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] quo_step, rem_step;

    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        fits     = shifted >= {1'b0, dvs_q};
        rem_step = fits ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
        quo_step = {quo_q[30:0], fits};

        done_o      = busy_q && (cnt_q == 5'd31);
        quotient_o  = quo_step;
        remainder_o = rem_step;

        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end else if (busy_q) begin
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q + 5'd1;
            if (done_o) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// EXE-stage multi-cycle multiply/divide unit producing {HI,LO}; stalls the front
// of the pipe while busy and holds its result in DONE until MEM/WB can accept it.
module mdu_iterative
    import mdu_iterative_pkg::*;
#(
    parameter int MUL_STAGES     = 2,
    parameter int EARLY_DIV_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  EXE_ALUOp,
    input  logic        EXE_Valid,
    input  logic [31:0] EXE_SrcA,
    input  logic [31:0] EXE_SrcB,
    input  logic [63:0] HiLo_In,
    input  logic        Flush,
    input  logic        Downstream_Stall,
    output logic        MDU_Busy,
    output logic        MDU_Done,
    output logic [31:0] MDU_Hi,
    output logic [31:0] MDU_Lo
);
    localparam int         PIPE_LAST    = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;
    localparam logic [5:0] MUL_LAST_CNT = 6'(MUL_STAGES - 1);

    mdu_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic [31:0] a_q, b_q;
    logic        sgn_q;
    logic [63:0] mul_pipe_q [3];

    mdu_class_t         cls;
    logic               start, mul_start, div_start;
    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] prod;
    logic [63:0]        mul_res;
    logic [31:0]        div_a_abs, div_b_abs, div_quo, div_rem, quo_fix, rem_fix;
    logic               div_done, div_abort, div_zero;

    // Start decode and the product/accumulate, formed from the start-cycle operands.
    always_comb begin
        cls       = mdu_classify(EXE_ALUOp);
        start     = (state_q == ST_IDLE) && EXE_Valid && (cls.is_mul || cls.is_div) && !Flush;
        mul_start = start && cls.is_mul;
        div_start = start && cls.is_div;

        mul_a = cls.is_sgn ? {EXE_SrcA[31], EXE_SrcA} : {1'b0, EXE_SrcA};
        mul_b = cls.is_sgn ? {EXE_SrcB[31], EXE_SrcB} : {1'b0, EXE_SrcB};
        prod  = 64'(mul_a) * 64'(mul_b);
        if (!cls.is_acc)     mul_res = prod;
        else if (cls.is_sub) mul_res = HiLo_In - prod;
        else                 mul_res = HiLo_In + prod;

        div_a_abs = (cls.is_sgn && EXE_SrcA[31]) ? (32'd0 - EXE_SrcA) : EXE_SrcA;
        div_b_abs = (cls.is_sgn && EXE_SrcB[31]) ? (32'd0 - EXE_SrcB) : EXE_SrcB;

        div_zero  = (b_q == 32'd0);
        div_abort = Flush || ((state_q == ST_DIV) && div_zero && (EARLY_DIV_ZERO != 0));
        quo_fix   = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - div_quo) : div_quo;
        rem_fix   = (sgn_q && a_q[31]) ? (32'd0 - div_rem) : div_rem;
    end

    div_radix2_iter u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .abort_i     (div_abort),
        .dividend_i  (div_a_abs),
        .divisor_i   (div_b_abs),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: if (start) begin
                cnt_d = 6'd1;
                if (cls.is_div)           state_d = ST_DIV;
                else if (MUL_STAGES > 1)  state_d = ST_MUL;
                else begin
                    res_d   = mul_res;
                    state_d = ST_DONE;
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == MUL_LAST_CNT) begin
                    res_d   = mul_pipe_q[PIPE_LAST];
                    state_d = ST_DONE;
                end
            end
            // A zero divisor reports the raw dividend with an all-ones quotient, no sign fix.
            ST_DIV: begin
                if (div_zero && ((EARLY_DIV_ZERO != 0) || div_done)) begin
                    res_d   = {a_q, 32'hFFFF_FFFF};
                    state_d = ST_DONE;
                end else if (div_done) begin
                    res_d   = {rem_fix, quo_fix};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (!Downstream_Stall) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (Flush) begin
            state_d = ST_IDLE;
            res_d   = res_q;
        end

        MDU_Busy = (((state_q == ST_MUL) || (state_q == ST_DIV)) && !Flush) || start;
        MDU_Done = (state_q == ST_DONE) && !Flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            for (int i = 0; i < 3; i++) mul_pipe_q[i] <= '0;
        end else begin
            res_q <= res_d;
            if (start) begin
                a_q   <= EXE_SrcA;
                b_q   <= EXE_SrcB;
                sgn_q <= cls.is_sgn;
            end
            if (mul_start) mul_pipe_q[0] <= mul_res;
            if (state_q == ST_MUL) begin
                mul_pipe_q[1] <= mul_pipe_q[0];
                mul_pipe_q[2] <= mul_pipe_q[1];
            end
        end
    end

    assign MDU_Hi = res_q[63:32];
    assign MDU_Lo = res_q[31:0];

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed and random ops checked against an arithmetic
// reference model, plus flush, stall, reset and non-MDU-opcode scenarios.
module tb_mdu_iterative;
    import mdu_iterative_pkg::*;

    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        rst;
    InstrType    alu_op;
    logic        valid;
    logic [31:0] src_a, src_b;
    logic [63:0] hilo_in;
    logic        flush;
    logic        stall_in;
    logic        mdu_busy, mdu_done;
    logic [31:0] mdu_hi, mdu_lo;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] last_res;

    mdu_iterative #(.MUL_STAGES(MS), .EARLY_DIV_ZERO(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .EXE_ALUOp        (alu_op),
        .EXE_Valid        (valid),
        .EXE_SrcA         (src_a),
        .EXE_SrcB         (src_b),
        .HiLo_In          (hilo_in),
        .Flush            (flush),
        .Downstream_Stall (stall_in),
        .MDU_Busy         (mdu_busy),
        .MDU_Done         (mdu_done),
        .MDU_Hi           (mdu_hi),
        .MDU_Lo           (mdu_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input InstrType op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hl);
        longint      sa64, sb64, sp;
        logic [63:0] ua, ub, up;
        int          sa, sb, q, r;
        sa64 = $signed(a);
        sb64 = $signed(b);
        sp   = sa64 * sb64;
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        up   = ua * ub;
        case (op)
            OP_MULT, OP_MUL: return sp;
            OP_MULTU:        return up;
            OP_MADD:         return hl + sp;
            OP_MADDU:        return hl + up;
            OP_MSUB:         return hl - sp;
            OP_MSUBU:        return hl - up;
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int exp_latency(input InstrType op, input logic [31:0] b);
        if (op == OP_DIV || op == OP_DIVU) return (b == 32'd0) ? 2 : 33;
        return MS;
    endfunction

    // Issue one op at the next negedge (cycle T), hold it in EXE while busy, check latency,
    // result, optional DONE stall, and the return to IDLE.
    task automatic do_op(input InstrType op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] hl, input int stall, input string tag);
        logic [63:0] exp;
        int          lat, k;
        bit          done_seen, busy_ok;
        exp = ref_model(op, a, b, hl);
        lat = exp_latency(op, b);
        @(negedge clk);
        alu_op = op; src_a = a; src_b = b; hilo_in = hl;
        valid = 1'b1; flush = 1'b0; stall_in = 1'b0;
        #1;
        chk({tag, ":busy_T"}, 64'(mdu_busy), 64'd1);
        k = 0; done_seen = 0; busy_ok = 1;
        while (!done_seen && k < 80) begin
            @(negedge clk);
            k++;
            src_a = $urandom; src_b = $urandom; hilo_in = {$urandom, $urandom};
            stall_in = (stall > 0) && (k >= lat);
            #1;
            if (mdu_done) done_seen = 1;
            else if (!mdu_busy) busy_ok = 0;
        end
        chk({tag, ":latency"}, 64'(k), 64'(lat));
        chk({tag, ":busy_until_done"}, 64'(busy_ok), 64'd1);
        chk({tag, ":busy_at_done"}, 64'(mdu_busy), 64'd0);
        chk({tag, ":hilo"}, {mdu_hi, mdu_lo}, exp);
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            stall_in = (s < stall);
            #1;
            chk({tag, ":stall_done"}, 64'(mdu_done), 64'd1);
            chk({tag, ":stall_hilo"}, {mdu_hi, mdu_lo}, exp);
        end
        valid = 1'b0; stall_in = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, ":idle_done"}, 64'(mdu_done), 64'd0);
        chk({tag, ":idle_busy"}, 64'(mdu_busy), 64'd0);
        chk({tag, ":idle_hilo"}, {mdu_hi, mdu_lo}, exp);
        last_res = exp;
    endtask

    InstrType ops [9] = '{OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
                          OP_MUL, OP_DIV, OP_DIVU};

    initial begin
        bit no_done;
        rst = 1'b1; alu_op = OP_NOP; valid = 1'b0; src_a = '0; src_b = '0;
        hilo_in = '0; flush = 1'b0; stall_in = 1'b0; last_res = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", 64'(mdu_busy), 64'd0);
        chk("reset_done", 64'(mdu_done), 64'd0);
        chk("reset_hilo", {mdu_hi, mdu_lo}, 64'd0);
        rst = 1'b0;

        do_op(OP_MULT,  32'hFFFF_FFFE, 32'h3, 64'd0, 0, "mult");
        do_op(OP_MULTU, 32'hFFFF_FFFE, 32'h3, 64'd0, 0, "multu");
        do_op(OP_MADD,  32'h1, 32'h1, 64'h0000_0000_FFFF_FFFF, 0, "madd");
        do_op(OP_MSUBU, 32'h1, 32'h1, 64'd0, 0, "msubu");
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'h2, 64'd0, 0, "div_neg7_2");
        do_op(OP_DIVU,  32'd100, 32'd7, 64'd0, 0, "divu_100_7");
        do_op(OP_DIVU,  32'd5, 32'd0, 64'd0, 0, "divu_by_zero");
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 0, "div_ovf");
        do_op(OP_MSUB,  32'h0000_1234, 32'hFFFF_FF00, 64'h0123_4567_89AB_CDEF, 0, "msub");
        do_op(OP_MUL,   32'h0001_0001, 32'h0001_0001, 64'd0, 3, "mul_stall3");
        do_op(OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 64'd0, 3, "div_stall3");

        // Non-MDU opcode must never start the unit.
        @(negedge clk);
        alu_op = OP_ADD; valid = 1'b1; src_a = 32'd3; src_b = 32'd4;
        #1;
        chk("nonmdu_busy", 64'(mdu_busy), 64'd0);
        @(negedge clk);
        #1;
        chk("nonmdu_busy_next", 64'(mdu_busy), 64'd0);
        chk("nonmdu_done_next", 64'(mdu_done), 64'd0);
        valid = 1'b0;

        // Flush in the start cycle suppresses the start.
        @(negedge clk);
        alu_op = OP_DIV; valid = 1'b1; src_a = 32'd50; src_b = 32'd5; flush = 1'b1;
        #1;
        chk("flush_start_busy", 64'(mdu_busy), 64'd0);
        @(negedge clk);
        flush = 1'b0; valid = 1'b0;
        #1;
        chk("flush_start_busy_next", 64'(mdu_busy), 64'd0);
        no_done = 1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (mdu_done) no_done = 0;
        end
        chk("flush_start_no_done", 64'(no_done), 64'd1);
        chk("flush_start_hilo", {mdu_hi, mdu_lo}, last_res);

        // Flush at T+10 of a DIV, then a fresh DIV starting at T+12.
        @(negedge clk);
        alu_op = OP_DIV; valid = 1'b1; src_a = 32'd1000; src_b = 32'd3;
        no_done = 1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            src_a = $urandom; src_b = $urandom;
            #1;
            if (mdu_done) no_done = 0;
        end
        flush = 1'b1;
        #1;
        chk("flush_mid_busy", 64'(mdu_busy), 64'd0);
        chk("flush_mid_done", 64'(mdu_done), 64'd0);
        chk("flush_mid_hilo", {mdu_hi, mdu_lo}, last_res);
        @(negedge clk);
        flush = 1'b0; valid = 1'b0;
        #1;
        if (mdu_done) no_done = 0;
        chk("flush_mid_idle_busy", 64'(mdu_busy), 64'd0);
        chk("flush_mid_no_done", 64'(no_done), 64'd1);
        do_op(OP_DIV, 32'hFFFF_FC18, 32'd7, 64'd0, 0, "div_after_flush");

        // Reset in the middle of a DIV.
        @(negedge clk);
        alu_op = OP_DIVU; valid = 1'b1; src_a = 32'd77; src_b = 32'd5;
        repeat (5) @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        #1;
        chk("midreset_busy", 64'(mdu_busy), 64'd0);
        chk("midreset_done", 64'(mdu_done), 64'd0);
        chk("midreset_hilo", {mdu_hi, mdu_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postreset_busy", 64'(mdu_busy), 64'd0);

        for (int n = 0; n < 16; n++) begin
            InstrType    op;
            logic [31:0] a, b;
            int          sel;
            op  = ops[$urandom_range(0, 8)];
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = {28'd0, b[3:0]};
            do_op(op, a, b, {$urandom, $urandom}, $urandom_range(0, 2), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit in the EXE stage. Executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MUL.
- Produces the Hi/Lo pair that EXE forwards to MEM. For OP_MUL, the low product word goes to the ALU result path.
- Stalls IF/ID/EXE while busy. Aborts on pipeline flush.

Parameters:
- MUL_STAGES, 2, cycles from start to Done for multiply-class ops. Legal values 1..3; internal product register depth.
- EARLY_DIV_ZERO, 1, if 1, a divide with divisor 0 completes in 2 cycles instead of 33.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous active-high reset
- EXE_ALUOp  input  7  InstrType opcode of the instruction in EXE
- EXE_Valid  input  1  EXE holds a real, non-excepting instruction
- EXE_SrcA  input  32  forwarded rs value
- EXE_SrcB  input  32  forwarded rt value
- HiLo_In  input  64  current committed {HI,LO}, forwarded; used by MADD/MSUB
- Flush  input  1  exception/ERET flush of EXE
- Downstream_Stall  input  1  MEM/WB stall; EXE cannot advance
- MDU_Busy  output  1  request stall of IF/ID/EXE
- MDU_Done  output  1  result valid this cycle
- MDU_Hi  output  32  result HI
- MDU_Lo  output  32  result LO (also the MUL rd result)

Behaviour:
- Reset: state IDLE; MDU_Busy=0, MDU_Done=0, MDU_Hi=0, MDU_Lo=0; all internal registers 0.
- Op classes:
  - MUL class: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL.
  - DIV class: DIV, DIVU.
  - Any other opcode: never starts the unit.
- Start condition: state IDLE, EXE_Valid=1, MDU op, Flush=0. Operands and HiLo_In are latched in the start cycle T. MDU_Busy is asserted combinationally from T itself, so EXE holds.
- States and transitions:
  - IDLE → MUL or DIV on start.
  - MUL:
    - 33x33 signed product; operands sign-extended for signed ops, zero-extended for unsigned.
    - Stage registers advance each cycle.
    - MADD/MADDU add the 64-bit product to HiLo_In; MSUB/MSUBU subtract it. Arithmetic is mod 2^64.
    - → DONE when the result is ready, so Done is asserted in cycle T+MUL_STAGES.
  - DIV:
    - Restoring radix-2, one quotient bit per cycle, 32 iterations on |A| and |B|.
    - Sign fix in the final cycle: quotient negative iff signA xor signB; remainder takes signA.
    - Done in cycle T+33.
    - Lo=quotient, Hi=remainder.
  - DONE:
    - MDU_Done=1, MDU_Busy=0; Hi/Lo stable.
    - Stays in DONE while Downstream_Stall=1.
    - → IDLE in the first cycle with Downstream_Stall=0 (EXE advances that edge).
    - A new start cannot occur in the DONE cycle. The same instruction must not restart: the instruction leaves EXE on that edge.
- MDU_Busy = (state in {MUL, DIV}) or start condition.
- Flush: in any state, next state is IDLE, Done=0, Busy=0, and Hi/Lo are unchanged. Flush in the start cycle suppresses the start.
- Boundary cases:
  - Divide by zero: Lo=0xFFFFFFFF, Hi=dividend (raw, unsigned-form result; signed ops apply no sign fix). With EARLY_DIV_ZERO=1 this completes at T+2.
  - DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No exception.
  - Operand changes after T are ignored.
  - Reset mid-operation: immediate return to IDLE with outputs cleared.
- The MDU writes no HI/LO registers itself; commit happens in WB via RegsWrType.HIWr/LOWr.

Decomposition:
- Shared package: InstrType (existing), an MDU state enum (IDLE, MUL, DIV, DONE), and a helper function classifying an opcode as mul-class, div-class, signed, or accumulate-type.
- Natural sub-module: div_radix2_iter, a 32-bit iterative unsigned divider with start/done handshake. The parent handles signs and zero-divisor.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003 → Done at T+2, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; MULTU with the same operands → Hi=0x00000002, Lo=0xFFFFFFFA.
- MADD with HiLo_In=0x00000000_FFFFFFFF, operands 1 and 1 → Hi=0x00000001, Lo=0x00000000. MSUBU with HiLo_In=0, operands 1 and 1 → Hi=Lo=0xFFFFFFFF.
- DIV -7 (0xFFFFFFF9) / 2 → Done at T+33, Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100/7 → Lo=14, Hi=2. Busy is high for cycles T..T+32.
- DIVU 5/0 with EARLY_DIV_ZERO=1 → Done at T+2, Lo=0xFFFFFFFF, Hi=5. DIV 0x80000000/-1 → Lo=0x80000000, Hi=0.
- Flush asserted at T+10 of a DIV → IDLE at T+11, no Done ever. A new DIV started at T+12 completes correctly at T+45.
- Downstream_Stall held for 3 cycles in DONE → Done and Hi/Lo stay stable for 4 cycles, then IDLE, with no restart.
